// File: rtl/pkt_switch_router_pkg.sv
// Shared types and helpers for the packet switch core.
// Receive FSM states, frame field positions and broadcast DA detection.
package pkt_switch_router_pkg;

    typedef enum logic [1:0] {
        S_DA,
        S_SA,
        S_LEN,
        S_PAY
    } rx_state_t;

    localparam int FLD_DA    = 0;
    localparam int FLD_SA    = 1;
    localparam int FLD_LEN   = 2;
    localparam int HDR_BYTES = 3;

    // True when the low w bits of da are all ones (the broadcast DA).
    function automatic logic is_bcast(input logic [31:0] da, input int unsigned w);
        logic [31:0] m;
        m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (da & m) == m;
    endfunction

endpackage

// File: rtl/pkt_switch_router_if.sv
// Bus bundle of the packet switch: config port, ingress stream, egress ports.
// master drives config/ingress/pops, slave is the switch core.
interface pkt_switch_router_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 4
);
    localparam int CFG_AW = $clog2(NUM_PORTS + 1);

    logic                        mem_en;
    logic                        mem_rd_wr;
    logic [CFG_AW-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        data_valid;
    logic [DATA_W-1:0]           data;
    logic                        data_stall;
    logic [NUM_PORTS-1:0]        port_read;
    logic [NUM_PORTS-1:0]        port_ready;
    logic [NUM_PORTS*DATA_W-1:0] port_data;

    modport master (
        output mem_en, mem_rd_wr, mem_addr, mem_wdata,
        output data_valid, data, port_read,
        input  mem_rdata, data_stall, port_ready, port_data
    );

    modport slave (
        input  mem_en, mem_rd_wr, mem_addr, mem_wdata,
        input  data_valid, data, port_read,
        output mem_rdata, data_stall, port_ready, port_data
    );

endinterface

// File: rtl/pkt_switch_router_fifo.sv
// First-word-fall-through synchronous FIFO for one egress port.
// Head word is visible while non-empty; reads 0 when empty.
module pkt_switch_router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    // Push is gated by the registered full even if a pop happens this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_switch_router.sv
// Packet switch core: DA match against port address registers, per-port
// egress FIFOs, broadcast delivery and a saturating drop counter.
module pkt_switch_router
    import pkt_switch_router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter bit BCAST_EN   = 1'b1
) (
    input  logic              fast_clk,
    input  logic              reset_b,
    pkt_switch_router_if.slave bus
);
    localparam int CFG_AW = $clog2(NUM_PORTS + 1);

    rx_state_t            state_q;
    logic [NUM_PORTS-1:0] tgt_mask_q;
    logic                 drop_q;
    logic [DATA_W-1:0]    rem_q;
    logic [DATA_W-1:0]    port_addr_q [NUM_PORTS];
    logic [DATA_W-1:0]    drop_cnt_q;
    logic [DATA_W-1:0]    rdata_q;

    logic [NUM_PORTS-1:0] match_mask;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] push;
    logic [DATA_W-1:0]    fifo_dout [NUM_PORTS];
    logic [DATA_W-1:0]    rd_mux;
    logic                 stall;
    logic                 accept;
    logic                 cfg_wr;
    logic                 cfg_rd;

    // Lowest matching port wins, so iterate downwards and let it overwrite.
    always_comb begin
        match_mask = '0;
        if (BCAST_EN && is_bcast(32'(bus.data), DATA_W)) begin
            match_mask = '1;
        end else begin
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (port_addr_q[p] == bus.data) begin
                    match_mask    = '0;
                    match_mask[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (state_q == S_DA) begin
            stall = |(match_mask & fifo_full);
        end else begin
            stall = |(tgt_mask_q & fifo_full) && !drop_q;
        end
    end

    assign accept = bus.data_valid && !stall;

    always_comb begin
        push = '0;
        if (accept) begin
            if (state_q == S_DA) begin
                push = match_mask;
            end else if (!drop_q) begin
                push = tgt_mask_q;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= S_DA;
            tgt_mask_q <= '0;
            drop_q     <= 1'b0;
            rem_q      <= '0;
            drop_cnt_q <= '0;
        end else if (accept) begin
            unique case (state_q)
                S_DA: begin
                    tgt_mask_q <= match_mask;
                    drop_q     <= (match_mask == '0);
                    if (match_mask == '0 && drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                    state_q <= S_SA;
                end
                S_SA: state_q <= S_LEN;
                S_LEN: begin
                    rem_q   <= bus.data;
                    state_q <= (bus.data == '0) ? S_DA : S_PAY;
                end
                S_PAY: begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == DATA_W'(1)) state_q <= S_DA;
                end
                default: state_q <= S_DA;
            endcase
        end
    end

    assign cfg_wr = bus.mem_en && bus.mem_rd_wr;
    assign cfg_rd = bus.mem_en && !bus.mem_rd_wr;

    always_comb begin
        rd_mux = '0;
        if (bus.mem_addr == CFG_AW'(NUM_PORTS)) begin
            rd_mux = drop_cnt_q;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.mem_addr == CFG_AW'(p)) rd_mux = port_addr_q[p];
        end
    end

    always_ff @(posedge fast_clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                port_addr_q[p] <= DATA_W'(p);
            end
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cfg_wr && bus.mem_addr == CFG_AW'(p)) begin
                    port_addr_q[p] <= bus.mem_wdata;
                end
            end
            if (cfg_rd) rdata_q <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        pkt_switch_router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (fast_clk),
            .rst_ni  (reset_b),
            .push_i  (push[g]),
            .pop_i   (bus.port_read[g]),
            .din_i   (bus.data),
            .dout_o  (fifo_dout[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
        assign bus.port_data[g*DATA_W +: DATA_W] = fifo_dout[g];
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.data_stall = stall;
    assign bus.port_ready = ~fifo_empty;

endmodule

// File: tb/tb_pkt_switch_router.sv
// Scoreboard bench for pkt_switch_router: directed frames, config access,
// back-pressure, broadcast, drop counting and mid-frame reset.
module tb_pkt_switch_router;
    import pkt_switch_router_pkg::*;

    localparam int DW   = 8;
    localparam int NP   = 4;
    localparam int FD   = 16;
    localparam int FREE = 1000000;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    pkt_switch_router_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

    pkt_switch_router #(
        .DATA_W     (DW),
        .NUM_PORTS  (NP),
        .FIFO_DEPTH (FD),
        .BCAST_EN   (1'b1)
    ) dut (
        .fast_clk (clk),
        .reset_b  (rst_b),
        .bus      (bus)
    );

    bq_t  exp_q [NP];
    bq_t  rd_q;
    int   pop_budget [NP];
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    logic rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: pops ports that have budget and compares head with scoreboard.
    initial begin
        bus.port_read = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                bus.port_read[p] = 1'b0;
                if (rst_b && bus.port_ready[p] && pop_budget[p] > 0) begin
                    if (exp_q[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL port%0d unexpected: got %0h want none", p,
                                 bus.port_data[p*DW +: DW]);
                    end else begin
                        chk($sformatf("port%0d data", p), 32'(bus.port_data[p*DW +: DW]),
                            32'(exp_q[p].pop_front()));
                    end
                    bus.port_read[p] = 1'b1;
                    pop_budget[p]--;
                end
            end
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata unexpected: got %0h want none", bus.mem_rdata);
                end else begin
                    chk("rdata", 32'(bus.mem_rdata), 32'(rd_q.pop_front()));
                end
            end
            rd_pend = bus.mem_en && !bus.mem_rd_wr && rst_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_budget(input int v);
        for (int p = 0; p < NP; p++) pop_budget[p] = v;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] v);
        bus.mem_en = 1'b1;
        bus.mem_rd_wr = 1'b1;
        bus.mem_addr = a;
        bus.mem_wdata = v;
        tick();
        bus.mem_en = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, input logic [7:0] e);
        bus.mem_en = 1'b1;
        bus.mem_rd_wr = 1'b0;
        bus.mem_addr = a;
        rd_q.push_back(e);
        tick();
        bus.mem_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        bus.data_valid = 1'b1;
        bus.data = b;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!bus.data_stall) break;
            stalls++;
            if (stalls > 300) begin
                checks++;
                errors++;
                $display("FAIL byte timeout: got stall want accept of %0h", b);
                break;
            end
        end
        @(posedge clk);
        acc_cnt++;
        #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] mask, input bq_t f, output int stalls);
        int s;
        stalls = 0;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                foreach (f[i]) exp_q[p].push_back(f[i]);
            end
        end
        foreach (f[i]) begin
            send_byte(f[i], s);
            stalls += s;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        int left;
        n = 0;
        left = 1;
        while (left != 0 && n < 500) begin
            left = 0;
            for (int p = 0; p < NP; p++) left += exp_q[p].size();
            if (bus.port_ready != '0) left++;
            if (left != 0) tick();
            n++;
        end
        chk({name, " left"}, 32'(left), 32'd0);
    endtask

    initial begin
        bq_t f;
        int  st;
        int  st_bg;
        int  acc0;

        set_budget(0);
        bus.mem_en = 1'b0;
        bus.mem_rd_wr = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        bus.data_valid = 1'b0;
        bus.data = '0;

        repeat (3) tick();
        chk("rst rdata", 32'(bus.mem_rdata), 32'd0);
        chk("rst stall", 32'(bus.data_stall), 32'd0);
        chk("rst ready", 32'(bus.port_ready), 32'd0);
        chk("rst pdata", bus.port_data, 32'd0);
        rst_b = 1'b1;
        tick();

        // Reset values of the config space, including out-of-range addresses.
        for (int a = 0; a < NP; a++) cfg_read(3'(a), 8'(a));
        cfg_read(3'd4, 8'd0);
        cfg_read(3'd5, 8'd0);
        cfg_read(3'd7, 8'd0);
        tick();

        cfg_write(3'd2, 8'h55);
        pop_budget[2] = FREE;
        f = '{8'h55, 8'h01, 8'h02, 8'hAA, 8'hBB};
        send_frame(4'b0100, f, st);
        chk("t2 stall", 32'(st), 32'd0);
        chk("t2 others", 32'(bus.port_ready & 4'b1011), 32'd0);
        wait_drain("t2");

        f = '{8'h77, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(4'b0000, f, st);
        chk("t3 stall", 32'(st), 32'd0);
        tick();
        chk("t3 ready", 32'(bus.port_ready), 32'd0);
        cfg_read(3'd4, 8'd1);
        tick();

        set_budget(0);
        f = '{8'hFF, 8'h01, 8'h00};
        send_frame(4'b1111, f, st);
        tick();
        chk("t4 bcast ready", 32'(bus.port_ready), 32'hF);
        set_budget(FREE);
        wait_drain("t4a");

        // Port1 at FIFO_DEPTH-1 words; broadcast DA fills it, SA stalls.
        set_budget(0);
        f = '{8'h01, 8'h09, 8'h0C};
        for (int i = 0; i < f[FLD_LEN]; i++) f.push_back(8'h30 + 8'(i));
        send_frame(4'b0010, f, st);
        chk("t4 fill ready", 32'(bus.port_ready), 32'b0010);
        acc0 = acc_cnt;
        f = '{8'hFF, 8'h02, 8'h00};
        fork
            send_frame(4'b1111, f, st_bg);
        join_none
        repeat (6) tick();
        chk("t4 stall sa", 32'(bus.data_stall), 32'd1);
        chk("t4 acc da", 32'(acc_cnt - acc0), 32'd1);
        pop_budget[1] = 1;
        repeat (4) tick();
        chk("t4 stall len", 32'(bus.data_stall), 32'd1);
        chk("t4 acc sa", 32'(acc_cnt - acc0), 32'd2);
        pop_budget[1] = 1;
        repeat (4) tick();
        chk("t4 acc len", 32'(acc_cnt - acc0), 32'd3);
        set_budget(FREE);
        wait_drain("t4b");
        tick();

        // Port0 completely full: DA 00 must be held until one pop.
        set_budget(0);
        f = '{8'h00, 8'h05, 8'h0D};
        for (int i = 0; i < f[FLD_LEN]; i++) f.push_back(8'h40 + 8'(i));
        send_frame(4'b0001, f, st);
        chk("t5 fill ready", 32'(bus.port_ready), 32'b0001);
        acc0 = acc_cnt;
        f = '{8'h00, 8'h06, 8'h00};
        fork
            send_frame(4'b0001, f, st_bg);
        join_none
        repeat (5) tick();
        chk("t5 stall da", 32'(bus.data_stall), 32'd1);
        chk("t5 held da", 32'(acc_cnt - acc0), 32'd0);
        pop_budget[0] = 1;
        repeat (2) tick();
        chk("t5 da accepted", 32'(acc_cnt - acc0), 32'd1);
        set_budget(FREE);
        wait_drain("t5");
        tick();
        chk("t5 acc all", 32'(acc_cnt - acc0), 32'd3);

        // Drop counter saturates at all ones.
        f = '{8'h77, 8'h00, 8'h00};
        for (int i = 0; i < 260; i++) send_frame(4'b0000, f, st);
        cfg_read(3'd4, 8'hFF);
        tick();

        // Reset mid-payload clears FIFOs at once and restarts the FSM.
        set_budget(0);
        f = '{8'h03, 8'h01, 8'h05, 8'hA0, 8'hA1};
        foreach (f[i]) send_byte(f[i], st);
        chk("t6 pre ready", 32'(bus.port_ready), 32'b1000);
        rst_b = 1'b0;
        #1;
        chk("t6 rst ready", 32'(bus.port_ready), 32'd0);
        chk("t6 rst pdata", bus.port_data, 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        cfg_read(3'd2, 8'd2);
        cfg_read(3'd4, 8'd0);
        set_budget(FREE);
        f = '{8'h02, 8'h07, 8'h01, 8'hAB};
        send_frame(4'b0100, f, st);
        wait_drain("t6");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
